// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, word geometry.
package lsu_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;
endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extract+extend a load lane, merge a store lane into a read word.
// Zero latency; no flow control.
module lsu_lane import lsu_pkg::*; (
  input  logic [31:0] read_word,
  input  logic [31:0] write_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_val = 8'h00;
    case (lane)
      2'd0: byte_val = read_word[7:0];
      2'd1: byte_val = read_word[15:8];
      2'd2: byte_val = read_word[23:16];
      2'd3: byte_val = read_word[31:24];
      default: byte_val = 8'h00;
    endcase
    half_val  = lane[1] ? read_word[31:16] : read_word[15:0];
    byte_sign = byte_val[7] & ~is_unsigned;
    half_sign = half_val[15] & ~is_unsigned;

    load_data   = read_word;
    merged_word = write_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{byte_sign}}, byte_val};
        merged_word = read_word;
        case (lane)
          2'd0: merged_word[7:0]   = write_data[7:0];
          2'd1: merged_word[15:8]  = write_data[7:0];
          2'd2: merged_word[23:16] = write_data[7:0];
          2'd3: merged_word[31:24] = write_data[7:0];
          default: merged_word = read_word;
        endcase
      end
      SZ_HALF: begin
        load_data   = {{16{half_sign}}, half_val};
        merged_word = read_word;
        if (lane[1]) merged_word[31:16] = write_data[15:0];
        else         merged_word[15:0]  = write_data[15:0];
      end
      default: begin
        load_data   = read_word;
        merged_word = write_data;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: load and word store respond 2 cycles after accept, byte/half store 3; no response backpressure.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of silently aligning them.
module load_store_unit import lsu_pkg::*; #(
  parameter int MEM_WORDS = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);

  state_e            state;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wd_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       eff_addr;
  logic              misalign;
  logic              is_half;
  logic              is_word;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_merged;

  always_comb begin
    is_half = (req_size == SZ_HALF);
    is_word = req_size[1];
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    eff_addr = req_addr;
`else
    misalign = 1'b0;
    eff_addr = req_addr;
    if (is_word)      eff_addr[1:0] = 2'b00;
    else if (is_half) eff_addr[0]   = 1'b0;
`endif
  end

  lsu_lane u_lane (
    .read_word   (mem_read_data),
    .write_data  (wd_q),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (ld_data),
    .merged_word (st_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wd_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q    <= eff_addr;
          wd_q      <= req_wdata;
          size_q    <= req_size;
          uns_q     <= req_unsigned;
          rsp_rdata <= '0;
          rsp_err   <= misalign;
          if (misalign)       state <= RESP;
          else if (!req_write) state <= LD;
          else if (is_word)   state <= WR;
          else                state <= RMW_RD;
        end
        LD: begin
          rsp_rdata <= ld_data;
          state     <= RESP;
        end
        // Merged word replaces the store data so WR and RMW_WR share one write path.
        RMW_RD: begin
          wd_q  <= st_merged;
          state <= RMW_WR;
        end
        WR, RMW_WR: state <= RESP;
        RESP:       state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign rsp_valid      = (state == RESP);
  assign mem_address    = {addr_q[31:OFF_W+IDX_W], addr_q[OFF_W +: IDX_W], {OFF_W{1'b0}}};
  assign mem_write_data = wd_q;
  // Gated by rst so a reset landing on a write cycle never commits the write.
  assign mem_write      = ((state == WR) || (state == RMW_WR)) && !rst;
  assign mem_read       = ((state == LD) || (state == RMW_RD)) && !rst;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a posedge-write, combinational-read word memory.
module tb_load_store_unit;
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256];
  int n_vec = 0;
  int n_err = 0;
  vec_t vt[$];
  vec_t bq[3];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[9:2]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int rd, input int wrn, input int idx, input logic [31:0] m);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_rd = rd;
    v.exp_wr = wrn; v.mem_idx = idx; v.exp_mem = m;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_write    = v.wr;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic run_req(input vec_t v, input int id);
    int lat;
    int rd;
    int wrc;
    int w;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d ready", id), 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rd = 0;
    wrc = 0;
    for (lat = 1; lat <= 8; lat++) begin
      if (lat > 1) @(negedge clk);
      if (mem_read) rd++;
      if (mem_write) wrc++;
      if (rsp_valid) break;
    end
    check($sformatf("v%0d latency", id), lat, v.exp_lat);
    check($sformatf("v%0d rdata", id), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d err", id), 32'(rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d mem_reads", id), rd, v.exp_rd);
    check($sformatf("v%0d mem_writes", id), wrc, v.exp_wr);
    if (v.mem_idx >= 0) check($sformatf("v%0d mem word", id), mem[v.mem_idx[7:0]], v.exp_mem);
    @(negedge clk);
    check($sformatf("v%0d pulse end", id), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d ready after", id), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int r;
    int acc;
    logic pend;
    logic [31:0] saved;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h11223344;

    // wr, size, uns, addr, wdata, rdata, err, lat, reads, writes, mem idx, mem word
    vt.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 4, 32'hDEADBEEF));
    vt.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(1, 2'b00, 0, 32'h22, 32'h000000AA, 32'h0,        0, 3, 1, 1, 8, 32'h11AA3344));
    vt.push_back(mk(1, 2'b00, 0, 32'h23, 32'h00000080, 32'h0,        0, 3, 1, 1, 8, 32'h80AA3344));
    vt.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b00, 1, 32'h23, 32'h0,        32'h00000080, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0,        32'h000080AA, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFF80AA, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(1, 2'b01, 0, 32'h20, 32'hFFFF1234, 32'h0,        0, 3, 1, 1, 8, 32'h80AA1234));
    vt.push_back(mk(0, 2'b00, 0, 32'h21, 32'h0,        32'h00000012, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(1, 2'b00, 0, 32'h20, 32'h123456FF, 32'h0,        0, 3, 1, 1, 8, 32'h80AA12FF));
    vt.push_back(mk(0, 2'b00, 0, 32'h20, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b10, 0, 32'h410, 32'h0,       32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(mk(0, 2'b01, 0, 32'h21, 32'h0,        32'h0,        1, 1, 0, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 1, 0, 0, -1, 32'h0));
    vt.push_back(mk(1, 2'b01, 0, 32'h23, 32'h00005555, 32'h0,        1, 1, 0, 0, 8, 32'h80AA12FF));
    vt.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0, -1, 32'h0));
`else
    vt.push_back(mk(0, 2'b01, 0, 32'h21, 32'h0,        32'h000012FF, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0));
    vt.push_back(mk(1, 2'b01, 0, 32'h23, 32'h00005555, 32'h0,        0, 3, 1, 1, 8, 32'h555512FF));
    vt.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0,        32'h00000055, 0, 2, 1, 0, -1, 32'h0));
`endif

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset mem_read", 32'(mem_read), 32'd0);

    for (int i = 0; i < vt.size(); i++) run_req(vt[i], i);

    // Reset landing on the RMW write cycle must drop the write and the response.
    saved = mem[8];
    @(negedge clk);
    drive(mk(1, 2'b00, 0, 32'h20, 32'h00000077, 32'h0, 0, 3, 1, 1, 8, 32'h0));
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rmw read cycle", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rmw mem_write gated", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rmw req_ready", 32'(req_ready), 32'd1);
    check("rst_rmw rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rmw mem unchanged", mem[8], saved);
    @(negedge clk);
    check("rst_rmw no late rsp", 32'(rsp_valid), 32'd0);

    bq[0] = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, -1, 32'h0);
    bq[1] = mk(1, 2'b10, 0, 32'h30, 32'h01020304, 32'h0,        0, 2, 0, 1, 12, 32'h01020304);
    bq[2] = mk(0, 2'b10, 0, 32'h30, 32'h0,        32'h01020304, 0, 2, 1, 0, -1, 32'h0);
    @(negedge clk);
    k = 0;
    r = 0;
    drive(bq[0]);
    req_valid = 1'b1;
    pend = req_ready;
    acc = pend ? 1 : 0;
    for (int c = 0; c < 40 && r < 3; c++) begin
      @(negedge clk);
      if (pend) begin
        check($sformatf("b2b ready low after accept %0d", k), 32'(req_ready), 32'd0);
        k++;
        if (k < 3) drive(bq[k]);
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        check($sformatf("b2b rsp %0d rdata", r), rsp_rdata, bq[r].exp_rdata);
        check($sformatf("b2b rsp %0d ready", r), 32'(req_ready), 32'd0);
        r++;
      end
      pend = req_valid && req_ready;
      if (pend) acc++;
    end
    req_valid = 1'b0;
    check("b2b accepts", acc, 32'd3);
    check("b2b responses", r, 32'd3);
    check("b2b mem word", mem[12], 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
